pc_fetch_stage: RTL and testbench
=================================

# pc_fetch_stage

IF stage of the 5-stage MIPS core: owns the 12-bit byte-addressed PC register, drives the instruction ROM, and loads the IF/ID pipeline register. It feeds `pc_4` to the next-PC generator, takes the selected `npc` back on redirect, and honours load-use stalls and syscall halts. A run/halt state machine and a cycle counter sit here so the board display logic has a single source for "machine running" status.

## Interface
Parameters:
- `RESET_PC`, 12'h000: PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0000: instruction word inserted into IF/ID on flush or bubble (`sll $0,$0,0`).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  load-use hazard: hold the PC and IF/ID.
- `redirect`  in  1  taken branch, jump or `jr` resolved: load `npc`, flush IF/ID.
- `npc`  in  12  next PC from the next-PC generator.
- `halt_req`  in  1  syscall-halt decoded in ID.
- `go`  in  1  resume pulse (debounced board key).
- `step`  in  1  single-step pulse; exists only with `SINGLE_STEP_EN`.
- `imem_data`  in  32  combinational ROM read data for `imem_addr`.
- `imem_addr`  out  10  ROM word address, equal to `pc[11:2]` (combinational).
- `pc`  out  12  current PC register.
- `pc_4`  out  12  `pc + 4` modulo 2^12 (combinational).
- `if_id_instr`  out  32  IF/ID instruction.
- `if_id_pc_4`  out  12  IF/ID copy of `pc_4`.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `halted`  out  1  FSM is in HALT.
- `cycle_count`  out  32  number of cycles spent fetching.

## Operation
- FSM states: RUN, HALT, and STEP (STEP exists only with the macro). The reset state is RUN.
- Per-edge priority, highest first: `rst` > HALT/STEP handling > `halt_req` > `redirect` > `stall` > normal fetch.
- `rst`: `pc`=`RESET_PC`, `if_id_instr`=`NOP_INSTR`, `if_id_pc_4`=0, `if_id_valid`=0, `cycle_count`=0, state RUN. `halted` reads 0.
- RUN, normal fetch:
  - `pc`<=`pc_4`.
  - `if_id_instr`<=`imem_data`, `if_id_pc_4`<=`pc_4`, `if_id_valid`<=1.
- RUN, `redirect`:
  - `pc`<=`npc`.
  - IF/ID<=bubble (`NOP_INSTR`, `pc_4` field 0, valid 0).
  - `redirect` overrides a simultaneous `stall`.
- RUN, `stall` only: `pc` and IF/ID hold their values.
- RUN, `halt_req`:
  - `pc` holds; IF/ID<=bubble; next state HALT.
  - `halt_req` overrides a simultaneous `redirect`, `stall` or `go`.
- HALT:
  - `pc` holds; IF/ID<=bubble every cycle; `halted`=1.
  - `go`=1: next state RUN, and fetch resumes on the following edge.
  - `halt_req` is ignored while in HALT.
- `cycle_count` increments by 1 on each edge taken in RUN or STEP. It wraps from 0xFFFF_FFFF to 0.
- Arithmetic: `pc_4` is 12-bit, so PC 12'hFFC wraps to 12'h000. `npc[1:0]` is stored as given; `imem_addr` ignores bits [1:0].

## Timing
- Single cycle per fetch. `imem_data` must be valid in the same cycle as `imem_addr`; it is captured on that cycle's edge.
- Redirect asserted in cycle N: `pc`=`npc` in N+1; IF/ID is a bubble in N+1; the target instruction is in IF/ID in N+2.
- Stall asserted in cycles N..N+k: `pc` and IF/ID are unchanged through N+k+1. Fetch resumes at the edge ending the first cycle with `stall`=0.
- `halt_req` in cycle N: `halted`=1 from N+1.
- `go` in cycle M (while halted): `halted`=0 in M+1; the first real instruction is in IF/ID in M+2.
- `rst` asserted mid-operation (any state, any stall/redirect): all state takes reset values on that edge, unconditionally.

## Configuration
- `SINGLE_STEP_EN` defined:
  - The `step` port and the STEP state exist.
  - In HALT, a `step`=1 edge moves the FSM to STEP. `go` beats `step` if both are high.
  - In STEP, exactly one RUN-equivalent edge executes (normal fetch, or `redirect`/`stall` behaviour), with `cycle_count` incremented. The FSM then returns to HALT.
  - `halt_req` during STEP also returns the FSM to HALT and bubbles IF/ID.
  - `halted`=0 while in STEP.
- `SINGLE_STEP_EN` undefined:
  - There is no `step` port and no STEP state.
  - HALT is left only via `go` or `rst`.

## Test plan
- Reset, then run 3 cycles with the ROM returning word = address: `pc` steps 0x000→0x004→0x008→0x00C; `if_id_instr` steps 0,1,2; `cycle_count`=3.
- `redirect`=1 and `stall`=1 together at `pc`=0x010 with `npc`=0x100: next cycle `pc`=0x100 and `if_id_valid`=0. The cycle after, `if_id_pc_4`=0x104.
- `stall` held 2 cycles at `pc`=0x020: `pc` stays 0x020 and IF/ID is unchanged. Both advance on the first unstalled edge.
- `halt_req` at `pc`=0x040 → `halted`=1 and `pc` frozen at 0x040 for 5 cycles. `cycle_count` is frozen as well. `go` pulse → `pc`=0x044 two edges later.
- `pc` forced to 0xFFC: `pc_4`=0x000, and the next `pc`=0x000.
- With `SINGLE_STEP_EN`, halted at 0x040: each `step` pulse advances `pc` by exactly 4 and `cycle_count` by 1; `halted` returns to 1. Then `rst` asserted during STEP → `pc`=0x000, state RUN.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: IF stage of the 5-stage MIPS core.
//
// Owns the 12-bit byte-addressed PC, drives the instruction ROM address,
// loads the IF/ID pipeline register and runs the run/halt FSM together with
// the "cycles spent fetching" counter used by the board display.
//
// Optional feature macro: SINGLE_STEP_EN (adds the step port and STEP state).
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   stall        in   load-use hazard, hold PC and IF/ID
//   redirect     in   taken branch/jump/jr: load npc, flush IF/ID
//   npc[11:0]    in   next PC from the next-PC generator
//   halt_req     in   syscall halt decoded in ID
//   go           in   resume pulse
//   step         in   single-step pulse (SINGLE_STEP_EN only)
//   imem_data    in   combinational ROM data for imem_addr
//   imem_addr    out  ROM word address = pc[11:2]
//   pc           out  current PC register
//   pc_4         out  pc + 4 (mod 2^12)
//   if_id_instr  out  IF/ID instruction
//   if_id_pc_4   out  IF/ID copy of pc_4
//   if_id_valid  out  IF/ID holds a real instruction
//   halted       out  FSM is in HALT
//   cycle_count  out  edges taken in RUN/STEP
module pc_fetch_stage #(
  parameter logic [11:0] RESET_PC  = 12'h000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [11:0] npc,
  input  logic        halt_req,
  input  logic        go,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [31:0] imem_data,
  output logic [9:0]  imem_addr,
  output logic [11:0] pc,
  output logic [11:0] pc_4,
  output logic [31:0] if_id_instr,
  output logic [11:0] if_id_pc_4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] cycle_count
);

`ifdef SINGLE_STEP_EN
  typedef enum logic [1:0] {S_RUN, S_HALT, S_STEP} state_t;
`else
  typedef enum logic [0:0] {S_RUN, S_HALT} state_t;
`endif

  state_t      state, state_next;
  logic [11:0] pc_next;
  logic [31:0] instr_next;
  logic [11:0] pc4_next;
  logic        valid_next;
  logic [31:0] count_next;
  logic        bubble;

  assign pc_4      = pc + 12'd4;
  assign imem_addr = pc[11:2];
  assign halted    = (state == S_HALT);

  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = if_id_instr;
    pc4_next   = if_id_pc_4;
    valid_next = if_id_valid;
    count_next = cycle_count;
    bubble     = 1'b0;

    case (state)
      S_HALT: begin
        bubble = 1'b1;
        if (go) begin
          state_next = S_RUN;
        end
`ifdef SINGLE_STEP_EN
        else if (step) begin
          state_next = S_STEP;
        end
`endif
      end
      default: begin
        // RUN, and the single RUN-equivalent edge taken in STEP
        count_next = cycle_count + 32'd1;
        if (halt_req) begin
          bubble     = 1'b1;
          state_next = S_HALT;
        end else begin
          if (redirect) begin
            pc_next = npc;
            bubble  = 1'b1;
          end else if (!stall) begin
            pc_next    = pc_4;
            instr_next = imem_data;
            pc4_next   = pc_4;
            valid_next = 1'b1;
          end
`ifdef SINGLE_STEP_EN
          if (state == S_STEP) begin
            state_next = S_HALT;
          end
`endif
        end
      end
    endcase

    if (bubble) begin
      instr_next = NOP_INSTR;
      pc4_next   = '0;
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      pc          <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc_4  <= '0;
      if_id_valid <= 1'b0;
      cycle_count <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      if_id_instr <= instr_next;
      if_id_pc_4  <= pc4_next;
      if_id_valid <= valid_next;
      cycle_count <= count_next;
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed scenarios plus a
// randomized run compared each cycle against a behavioural reference model.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, redirect, halt_req, go, step;
  logic [11:0] npc;
  logic [31:0] imem_data;
  logic [9:0]  imem_addr;
  logic [11:0] pc, pc_4, if_id_pc_4;
  logic [31:0] if_id_instr, cycle_count;
  logic        if_id_valid, halted;

  // ROM content: word index, optionally scrambled by a constant mask
  logic [31:0] rom_xor = 32'h0;
  assign imem_data = {22'b0, imem_addr} ^ rom_xor;

  int errors = 0;
  int checks = 0;

  pc_fetch_stage #(.RESET_PC(12'h000), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .npc(npc),
    .halt_req(halt_req), .go(go),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .imem_data(imem_data), .imem_addr(imem_addr), .pc(pc), .pc_4(pc_4),
    .if_id_instr(if_id_instr), .if_id_pc_4(if_id_pc_4),
    .if_id_valid(if_id_valid), .halted(halted), .cycle_count(cycle_count)
  );

  // Reference model: architectural view of the stage
  logic [11:0] m_pc, m_pc4;
  logic [31:0] m_instr, m_cnt;
  logic        m_valid;
  bit          m_halted, m_stepping;

  function automatic logic [31:0] rom_word(input logic [11:0] a);
    return {22'b0, a[11:2]} ^ rom_xor;
  endfunction

  // One clock: drive inputs after the falling edge, advance the model at the
  // rising edge, return 1 time unit later so outputs are settled.
  task automatic cyc(input logic r, input logic st, input logic rd,
                     input logic [11:0] np, input logic hr, input logic g,
                     input logic sp);
    @(negedge clk);
    rst = r; stall = st; redirect = rd; npc = np; halt_req = hr; go = g; step = sp;
    @(posedge clk);
    if (r) begin
      m_pc = 12'h000; m_instr = 32'h0; m_pc4 = 12'h0; m_valid = 1'b0;
      m_cnt = 32'h0; m_halted = 0; m_stepping = 0;
    end else if (m_halted) begin
      m_instr = 32'h0; m_pc4 = 12'h0; m_valid = 1'b0;
      if (g) m_halted = 0;
`ifdef SINGLE_STEP_EN
      else if (sp) begin m_halted = 0; m_stepping = 1; end
`endif
    end else begin
      m_cnt = m_cnt + 32'd1;
      if (hr) begin
        m_instr = 32'h0; m_pc4 = 12'h0; m_valid = 1'b0;
        m_halted = 1; m_stepping = 0;
      end else begin
        if (rd) begin
          m_pc = np; m_instr = 32'h0; m_pc4 = 12'h0; m_valid = 1'b0;
        end else if (!st) begin
          m_instr = rom_word(m_pc);
          m_pc4   = m_pc + 12'd4;
          m_valid = 1'b1;
          m_pc    = m_pc + 12'd4;
        end
        if (m_stepping) begin m_stepping = 0; m_halted = 1; end
      end
    end
    #1;
  endtask

  task automatic fetch();
    cyc(0, 0, 0, 12'h0, 0, 0, 0);
  endtask

  task automatic test_reset();
    cyc(1, 1, 1, 12'h7F0, 1, 1, 1);
    checks++; if (pc !== 12'h000) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 12'h000); end
    checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", if_id_instr); end
    checks++; if (if_id_pc_4 !== 12'h0) begin errors++; $display("FAIL reset_pc4: got %h want 0", if_id_pc_4); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (cycle_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %h want 0", cycle_count); end
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 3; i++) begin
      fetch();
      checks++; if (pc !== 12'(4 * (i + 1))) begin errors++; $display("FAIL fetch_pc: got %h want %h", pc, 12'(4 * (i + 1))); end
      checks++; if (if_id_instr !== 32'(i)) begin errors++; $display("FAIL fetch_instr: got %h want %h", if_id_instr, 32'(i)); end
      checks++; if (if_id_pc_4 !== 12'(4 * (i + 1))) begin errors++; $display("FAIL fetch_pc4: got %h want %h", if_id_pc_4, 12'(4 * (i + 1))); end
      checks++; if (imem_addr !== 10'(i + 1)) begin errors++; $display("FAIL fetch_addr: got %h want %h", imem_addr, 10'(i + 1)); end
    end
    checks++; if (cycle_count !== 32'd3) begin errors++; $display("FAIL fetch_count: got %0d want 3", cycle_count); end
  endtask

  task automatic test_redirect_stall();
    fetch(); // pc = 0x010
    cyc(0, 1, 1, 12'h100, 0, 0, 0);
    checks++; if (pc !== 12'h100) begin errors++; $display("FAIL redir_pc: got %h want 100", pc); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b want 0", if_id_valid); end
    checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL redir_bubble: got %h want 0", if_id_instr); end
    fetch();
    checks++; if (if_id_pc_4 !== 12'h104) begin errors++; $display("FAIL redir_target_pc4: got %h want 104", if_id_pc_4); end
    checks++; if (if_id_instr !== 32'h40) begin errors++; $display("FAIL redir_target_instr: got %h want 40", if_id_instr); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL redir_target_valid: got %b want 1", if_id_valid); end
  endtask

  task automatic test_stall();
    cyc(0, 0, 1, 12'h01C, 0, 0, 0);
    fetch(); // pc = 0x020, IF/ID = word 7
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 0, 12'hABC, 0, 0, 0);
      checks++; if (pc !== 12'h020) begin errors++; $display("FAIL stall_pc: got %h want 020", pc); end
      checks++; if (if_id_instr !== 32'h7 || if_id_pc_4 !== 12'h020 || if_id_valid !== 1'b1) begin
        errors++; $display("FAIL stall_ifid: got %h/%h/%b want 7/020/1", if_id_instr, if_id_pc_4, if_id_valid); end
    end
    fetch();
    checks++; if (pc !== 12'h024) begin errors++; $display("FAIL stall_resume_pc: got %h want 024", pc); end
    checks++; if (if_id_instr !== 32'h8) begin errors++; $display("FAIL stall_resume_instr: got %h want 8", if_id_instr); end
  endtask

  task automatic test_halt();
    logic [31:0] c0;
    cyc(0, 0, 1, 12'h03C, 0, 0, 0);
    fetch(); // pc = 0x040
    c0 = cycle_count;
    cyc(0, 1, 1, 12'h200, 1, 1, 0); // halt_req beats redirect, stall and go
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_enter: got %b want 1", halted); end
    checks++; if (pc !== 12'h040) begin errors++; $display("FAIL halt_pc: got %h want 040", pc); end
    checks++; if (cycle_count !== c0 + 32'd1) begin errors++; $display("FAIL halt_edge_count: got %0d want %0d", cycle_count, c0 + 32'd1); end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1'(i), 1, 12'h300, 1'(i + 1), 0, 0);
      checks++; if (halted !== 1'b1 || pc !== 12'h040 || if_id_valid !== 1'b0) begin
        errors++; $display("FAIL halt_hold: got halted=%b pc=%h valid=%b want 1/040/0", halted, pc, if_id_valid); end
      checks++; if (cycle_count !== c0 + 32'd1) begin errors++; $display("FAIL halt_count: got %0d want %0d", cycle_count, c0 + 32'd1); end
    end
    cyc(0, 0, 0, 12'h0, 0, 1, 0);
    checks++; if (halted !== 1'b0 || pc !== 12'h040) begin errors++; $display("FAIL go_exit: got halted=%b pc=%h want 0/040", halted, pc); end
    fetch();
    checks++; if (pc !== 12'h044) begin errors++; $display("FAIL go_resume_pc: got %h want 044", pc); end
    checks++; if (if_id_instr !== 32'h10 || if_id_valid !== 1'b1) begin errors++; $display("FAIL go_resume_ifid: got %h/%b want 10/1", if_id_instr, if_id_valid); end
    checks++; if (cycle_count !== c0 + 32'd2) begin errors++; $display("FAIL go_resume_count: got %0d want %0d", cycle_count, c0 + 32'd2); end
  endtask

  task automatic test_wrap();
    cyc(0, 0, 1, 12'hFFC, 0, 0, 0);
    checks++; if (pc_4 !== 12'h000) begin errors++; $display("FAIL wrap_pc4: got %h want 000", pc_4); end
    checks++; if (imem_addr !== 10'h3FF) begin errors++; $display("FAIL wrap_addr: got %h want 3ff", imem_addr); end
    fetch();
    checks++; if (pc !== 12'h000) begin errors++; $display("FAIL wrap_pc: got %h want 000", pc); end
    checks++; if (if_id_instr !== 32'h3FF || if_id_pc_4 !== 12'h000) begin errors++; $display("FAIL wrap_ifid: got %h/%h want 3ff/000", if_id_instr, if_id_pc_4); end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_step();
    logic [31:0] c0;
    logic [11:0] p0;
    cyc(1, 0, 0, 12'h0, 0, 0, 0);
    cyc(0, 0, 1, 12'h03C, 0, 0, 0);
    fetch();
    cyc(0, 0, 0, 12'h0, 1, 0, 0); // halted at 0x040
    for (int i = 0; i < 3; i++) begin
      p0 = pc; c0 = cycle_count;
      cyc(0, 0, 0, 12'h0, 0, 0, 1);
      checks++; if (halted !== 1'b0 || pc !== p0) begin errors++; $display("FAIL step_enter: got halted=%b pc=%h want 0/%h", halted, pc, p0); end
      fetch();
      checks++; if (pc !== p0 + 12'd4) begin errors++; $display("FAIL step_pc: got %h want %h", pc, p0 + 12'd4); end
      checks++; if (cycle_count !== c0 + 32'd1) begin errors++; $display("FAIL step_count: got %0d want %0d", cycle_count, c0 + 32'd1); end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL step_rehalt: got %b want 1", halted); end
    end
    cyc(0, 0, 0, 12'h0, 0, 0, 1);
    cyc(1, 0, 0, 12'h0, 0, 0, 0);
    checks++; if (pc !== 12'h000 || halted !== 1'b0) begin errors++; $display("FAIL step_rst: got pc=%h halted=%b want 000/0", pc, halted); end
    fetch();
    checks++; if (pc !== 12'h004 || halted !== 1'b0) begin errors++; $display("FAIL step_rst_run: got pc=%h halted=%b want 004/0", pc, halted); end
  endtask
`endif

  task automatic test_random();
    rom_xor = $urandom;
    cyc(1, 0, 0, 12'h0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 4) == 0), 12'($urandom),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0));
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc: cyc %0d got %h want %h", i, pc, m_pc); end
      checks++; if (pc_4 !== m_pc + 12'd4) begin errors++; $display("FAIL rnd_pc4: cyc %0d got %h want %h", i, pc_4, m_pc + 12'd4); end
      checks++; if (imem_addr !== m_pc[11:2]) begin errors++; $display("FAIL rnd_addr: cyc %0d got %h want %h", i, imem_addr, m_pc[11:2]); end
      checks++; if (if_id_instr !== m_instr) begin errors++; $display("FAIL rnd_instr: cyc %0d got %h want %h", i, if_id_instr, m_instr); end
      checks++; if (if_id_pc_4 !== m_pc4) begin errors++; $display("FAIL rnd_ifid_pc4: cyc %0d got %h want %h", i, if_id_pc_4, m_pc4); end
      checks++; if (if_id_valid !== m_valid) begin errors++; $display("FAIL rnd_valid: cyc %0d got %b want %b", i, if_id_valid, m_valid); end
      checks++; if (halted !== m_halted) begin errors++; $display("FAIL rnd_halted: cyc %0d got %b want %b", i, halted, m_halted); end
      checks++; if (cycle_count !== m_cnt) begin errors++; $display("FAIL rnd_count: cyc %0d got %0d want %0d", i, cycle_count, m_cnt); end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; npc = '0;
    halt_req = 1'b0; go = 1'b0; step = 1'b0;
    test_reset();
    test_fetch();
    test_redirect_stall();
    test_stall();
    test_halt();
    test_wrap();
`ifdef SINGLE_STEP_EN
    test_step();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
